// File: rtl/svc_ice40_pll_pkg.sv
// Shared types and frequency helpers for the iCE40 PLL manager.
package svc_ice40_pll_pkg;

   typedef enum logic [1:0] {
      RESET     = 2'd0,
      WAIT_LOCK = 2'd1,
      LOCKED    = 2'd2
   } pll_mgr_state_t;

   // Frequencies in kHz so typical board oscillators stay exact.
   function automatic longint pll_pfd_khz(input longint fref_khz, input logic [3:0] divr);
      return fref_khz / (longint'(divr) + 64'sd1);
   endfunction

   function automatic longint pll_vco_khz(input longint fref_khz, input logic [3:0] divr,
                                          input logic [6:0] divf);
      return pll_pfd_khz(fref_khz, divr) * (longint'(divf) + 64'sd1);
   endfunction

   function automatic longint pll_fout_khz(input longint fref_khz, input logic [3:0] divr,
                                           input logic [6:0] divf, input logic [2:0] divq);
      return pll_vco_khz(fref_khz, divr, divf) >> divq;
   endfunction

endpackage

// File: rtl/svc_ice40_pll_core.sv
// Thin SB_PLL40_CORE wrapper; without SVC_ICE40_PLL_USE_SB a behavioural model whose LOCK rises
// SIM_LOCK_DLY cycles after RESETB goes high and drops as soon as RESETB goes low.
module svc_ice40_pll_core
   import svc_ice40_pll_pkg::*;
#(
   parameter logic [3:0] DIVR         = 4'd0,
   parameter logic [6:0] DIVF         = 7'd5,
   parameter logic [2:0] DIVQ         = 3'd3,
   parameter logic [2:0] FILTER_RANGE = 3'd5,
   parameter longint     FREF_KHZ     = 100000,
   parameter int         SIM_LOCK_DLY = 32
) (
   input  logic REFERENCECLK,
   input  logic RESETB,
   output logic LOCK,
   output logic PLLOUTGLOBAL
);

   localparam longint PFD_KHZ = pll_pfd_khz(FREF_KHZ, DIVR);
   localparam longint VCO_KHZ = pll_vco_khz(FREF_KHZ, DIVR, DIVF);

   // Refuse settings the silicon PLL cannot run at.
   if (PFD_KHZ < 10000 || PFD_KHZ > 133000 || VCO_KHZ < 533000 || VCO_KHZ > 1066000 ||
       DIVQ == 3'd0 || DIVQ == 3'd7 || FILTER_RANGE == 3'd0 || FILTER_RANGE == 3'd7) begin : g_cfg_err
      $error("svc_ice40_pll_core: PLL configuration out of range");
   end

`ifndef SVC_ICE40_PLL_USE_SB
   localparam int DW = $clog2(SIM_LOCK_DLY + 1) + 1;

   logic [DW-1:0] dly_q, dly_d;
   logic          lock_q, lock_d;

   always_comb begin
      dly_d  = dly_q;
      lock_d = lock_q;
      if (dly_q == DW'(SIM_LOCK_DLY - 1)) begin
         lock_d = 1'b1;
      end else begin
         dly_d = dly_q + DW'(1);
      end
   end

   always_ff @(posedge REFERENCECLK or negedge RESETB) begin
      if (!RESETB) begin
         dly_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         dly_q  <= dly_d;
         lock_q <= lock_d;
      end
   end

   assign LOCK         = lock_q;
   assign PLLOUTGLOBAL = REFERENCECLK;
`else
   SB_PLL40_CORE #(
      .FEEDBACK_PATH ("SIMPLE"),
      .DIVR          (DIVR),
      .DIVF          (DIVF),
      .DIVQ          (DIVQ),
      .FILTER_RANGE  (FILTER_RANGE)
   ) u_pll (
      .REFERENCECLK    (REFERENCECLK),
      .PLLOUTCORE      (),
      .PLLOUTGLOBAL    (PLLOUTGLOBAL),
      .EXTFEEDBACK     (1'b0),
      .DYNAMICDELAY    (8'd0),
      .LOCK            (LOCK),
      .BYPASS          (1'b0),
      .RESETB          (RESETB),
      .LATCHINPUTVALUE (1'b0),
      .SDI             (1'b0),
      .SCLK            (1'b0),
      .SDO             ()
   );
`endif

endmodule

// File: rtl/svc_sync.sv
// Multi-stage synchroniser cell for a single asynchronous level.
module svc_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/svc_ice40_pll_mgr.sv
// iCE40 PLL manager: sequences PLL reset, qualifies lock, retries on timeout, relocks on loss.
// Optional lock-loss counter enabled by defining SVC_ICE40_PLL_MGR_LOSS_CNT_EN.
module svc_ice40_pll_mgr
   import svc_ice40_pll_pkg::*;
#(
   parameter logic [3:0] DIVR         = 4'd0,
   parameter logic [6:0] DIVF         = 7'd5,
   parameter logic [2:0] DIVQ         = 3'd3,
   parameter logic [2:0] FILTER_RANGE = 3'd5,
   parameter longint     FREF_KHZ     = 100000,
   parameter int         RST_CYCLES   = 16,
   parameter int         LOCK_CYCLES  = 1024,
   parameter int         TIMEOUT      = 65536,
   parameter int         CNT_W        = 8,
   parameter int         SIM_LOCK_DLY = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic             clk_o,
   output logic             locked_o,
   output logic [CNT_W-1:0] retry_cnt_o,
   output logic [CNT_W-1:0] lock_loss_cnt_o
);

   localparam int RST_W = $clog2(RST_CYCLES) + 1;
   localparam int STB_W = $clog2(LOCK_CYCLES) + 1;
   localparam int TMO_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   pll_mgr_state_t   state_q, state_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [STB_W-1:0] stable_q, stable_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] retry_q, retry_d;
   logic             resetb_q, resetb_d;
   logic             locked_q, locked_d;
   logic             pll_lock;
   logic             lock_s;

   svc_ice40_pll_core #(
      .DIVR         (DIVR),
      .DIVF         (DIVF),
      .DIVQ         (DIVQ),
      .FILTER_RANGE (FILTER_RANGE),
      .FREF_KHZ     (FREF_KHZ),
      .SIM_LOCK_DLY (SIM_LOCK_DLY)
   ) u_core (
      .REFERENCECLK (clk_i),
      .RESETB       (resetb_q),
      .LOCK         (pll_lock),
      .PLLOUTGLOBAL (clk_o)
   );

   svc_sync #(.STAGES(2)) u_lock_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (pll_lock),
      .q_o    (lock_s)
   );

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      stable_d  = stable_q;
      tmo_d     = tmo_q;
      retry_d   = retry_q;
      unique case (state_q)
         RESET: begin
            if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
               state_d  = WAIT_LOCK;
               stable_d = '0;
               tmo_d    = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end
         WAIT_LOCK: begin
            tmo_d    = tmo_q + TMO_W'(1);
            stable_d = lock_s ? stable_q + STB_W'(1) : '0;
            // A qualified lock takes priority over a timeout landing on the same cycle.
            if (stable_q == STB_W'(LOCK_CYCLES)) begin
               state_d = LOCKED;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_d   = RESET;
               rst_cnt_d = '0;
               if (retry_q != CNT_MAX) begin
                  retry_d = retry_q + CNT_W'(1);
               end
            end
         end
         LOCKED: begin
            if (!lock_s) begin
               state_d   = RESET;
               rst_cnt_d = '0;
            end
         end
         default: begin
            state_d   = RESET;
            rst_cnt_d = '0;
         end
      endcase
      resetb_d = (state_d != RESET);
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RESET;
         rst_cnt_q <= '0;
         stable_q  <= '0;
         tmo_q     <= '0;
         retry_q   <= '0;
         resetb_q  <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         stable_q  <= stable_d;
         tmo_q     <= tmo_d;
         retry_q   <= retry_d;
         resetb_q  <= resetb_d;
         locked_q  <= locked_d;
      end
   end

`ifdef SVC_ICE40_PLL_MGR_LOSS_CNT_EN
   logic [CNT_W-1:0] loss_q, loss_d;

   always_comb begin
      loss_d = loss_q;
      if (state_q == LOCKED && !lock_s && loss_q != CNT_MAX) begin
         loss_d = loss_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign lock_loss_cnt_o = loss_q;
`else
   assign lock_loss_cnt_o = '0;
`endif

   assign locked_o    = locked_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_svc_ice40_pll_mgr.sv
// Self-checking bench for svc_ice40_pll_mgr: lock windows, retries, saturation, tie, loss, reset.
module tb_svc_ice40_pll_mgr;

   localparam int RST_C   = 4;
   localparam int LOCK_C  = 8;
   localparam int TMO_C   = 64;
   localparam int DLY     = 10;
   localparam int TIE_DLY = 53;
   localparam int NV      = 12;
`ifdef SVC_ICE40_PLL_MGR_LOSS_CNT_EN
   localparam int LOSS_EN = 1;
`else
   localparam int LOSS_EN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rst_aux_n = 1'b0;
   logic       clk_o_m, clk_o_s, clk_o_t;
   logic       locked_m, locked_s, locked_t;
   logic [7:0] retry_m, loss_m, retry_t, loss_t;
   logic [1:0] retry_s, loss_s;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   svc_ice40_pll_mgr #(.RST_CYCLES(RST_C), .LOCK_CYCLES(LOCK_C), .TIMEOUT(TMO_C),
                       .CNT_W(8), .SIM_LOCK_DLY(DLY)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clk_o(clk_o_m), .locked_o(locked_m),
      .retry_cnt_o(retry_m), .lock_loss_cnt_o(loss_m));

   svc_ice40_pll_mgr #(.RST_CYCLES(RST_C), .LOCK_CYCLES(LOCK_C), .TIMEOUT(TMO_C),
                       .CNT_W(2), .SIM_LOCK_DLY(DLY)) dut_sat (
      .clk_i(clk), .rst_ni(rst_aux_n), .clk_o(clk_o_s), .locked_o(locked_s),
      .retry_cnt_o(retry_s), .lock_loss_cnt_o(loss_s));

   svc_ice40_pll_mgr #(.RST_CYCLES(RST_C), .LOCK_CYCLES(LOCK_C), .TIMEOUT(TMO_C),
                       .CNT_W(8), .SIM_LOCK_DLY(TIE_DLY)) dut_tie (
      .clk_i(clk), .rst_ni(rst_aux_n), .clk_o(clk_o_t), .locked_o(locked_t),
      .retry_cnt_o(retry_t), .lock_loss_cnt_o(loss_t));

   typedef struct {
      int fs;       // LOCK forced low after edge fs ...
      int fe;       // ... and released after edge fe (fs < 0: no forcing)
      int loss_k;   // cycles spent in LOCKED before a lock loss is injected
      int lk_edge;  // expected edge (from rst_ni release) where locked_o rises
      int retries;  // expected retry_cnt_o at that point
   } vec_t;

   vec_t vecs[NV];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %0d", name, act);
      end
   endtask

   // Reference: LOCK as seen by the sampling flop at edge e is high once the PLL has had
   // dly cycles since RESETB rose, unless forced low. Ready needs LOCK_C consecutive high
   // samples, visible 3 edges later, no later than the attempt deadline (ties lock).
   function automatic void predict(input int dly, input int fs, input int fe,
                                   output int lk, output int retries);
      int start;
      int run;
      int deadline;
      bit hi;
      start   = 0;
      retries = 0;
      lk      = -1;
      for (int a = 0; a < 6; a++) begin
         if (lk < 0) begin
            run      = 0;
            deadline = start + RST_C + TMO_C;
            for (int e = start + RST_C + 1; e <= deadline - 3; e++) begin
               hi  = (e > start + RST_C + dly) && !(e > fs && e <= fe);
               run = hi ? run + 1 : 0;
               if (run == LOCK_C && lk < 0) lk = e + 3;
            end
            if (lk < 0) begin
               retries++;
               start = deadline;
            end
         end
      end
   endfunction

   task automatic apply_win(input int e, input int fs, input int fe);
      if (e == fs) force dut.pll_lock = 1'b0;
      if (e == fe) release dut.pll_lock;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int e;
      int n;
      int lk;
      int rt;
      int relock_exp;
      int tie_edge;
      int sat_locked;
      int ok;
      int fs;
      int fe;

      // Hand-picked windows: none, inert, first sample, late, long, tie, just past tie.
      vecs[0] = '{-1, -1,  5, 25, 0};
      vecs[1] = '{ 5,  6,  3, 25, 0};
      vecs[2] = '{14, 15,  0, 26, 0};
      vecs[3] = '{21, 22,  7, 33, 0};
      vecs[4] = '{10, 18, 12, 29, 0};
      vecs[5] = '{ 0, 57,  2, 68, 0};
      vecs[6] = '{ 0, 58,  9, 93, 1};
      for (int i = 7; i < NV; i++) begin
         ok = 0;
         for (int t = 0; t < 30 && ok == 0; t++) begin
            fs = int'($urandom_range(0, 60));
            fe = fs + int'($urandom_range(1, 8));
            predict(DLY, fs, fe, lk, rt);
            if (lk > 0 && fe < lk - 1) ok = 1;
         end
         if (ok == 0) begin
            fs = -1;
            fe = -1;
            predict(DLY, fs, fe, lk, rt);
         end
         vecs[i] = '{fs, fe, int'($urandom_range(0, 20)), lk, rt};
      end
      predict(DLY, -1, -1, relock_exp, rt);

      // Permanent lock failure with saturating 2-bit retries, plus the lock/timeout tie.
      force dut_sat.pll_lock = 1'b0;
      #1;
      check("sat_reset_retry", int'(retry_s), 0);
      check("tie_reset_locked", int'(locked_t), 0);
      @(negedge clk);
      rst_aux_n  = 1'b1;
      tie_edge   = -1;
      sat_locked = 0;
      for (e = 1; e <= 280; e++) begin
         @(negedge clk);
         if (locked_s) sat_locked++;
         if (locked_t && tie_edge < 0) tie_edge = e;
         if (e == 67 || e == 68 || e == 135 || e == 136 || e == 204 || e == 272 || e == 280)
            check($sformatf("sat_retry@%0d", e), int'(retry_s), (e / 68 > 3) ? 3 : e / 68);
      end
      predict(TIE_DLY, -1, -1, lk, rt);
      check("tie_lock_edge", tie_edge, lk);
      check("tie_retry", int'(retry_t), rt);
      check("sat_locked_cycles", sat_locked, 0);
      release dut_sat.pll_lock;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst_n = 1'b0;
         #1;
         check($sformatf("v%0d_rst_locked", i), int'(locked_m), 0);
         check($sformatf("v%0d_rst_resetb", i), int'(dut.resetb_q), 0);
         check($sformatf("v%0d_rst_retry", i), int'(retry_m), 0);
         check($sformatf("v%0d_rst_loss", i), int'(loss_m), 0);

         @(negedge clk);
         rst_n = 1'b1;
         e = 0;
         apply_win(e, vecs[i].fs, vecs[i].fe);
         while (locked_m !== 1'b1 && e < 400) begin
            @(negedge clk);
            e++;
            apply_win(e, vecs[i].fs, vecs[i].fe);
         end
         check($sformatf("v%0d_lock_edge(fs=%0d,fe=%0d)", i, vecs[i].fs, vecs[i].fe),
               e, vecs[i].lk_edge);
         check($sformatf("v%0d_retry", i), int'(retry_m), vecs[i].retries);

         repeat (vecs[i].loss_k) @(negedge clk);
         force dut.pll_lock = 1'b0;
         n = 0;
         while (locked_m === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("v%0d_loss_latency", i), n, 3);
         check($sformatf("v%0d_loss_resetb", i), int'(dut.resetb_q), 0);
         check($sformatf("v%0d_loss_cnt", i), int'(loss_m), LOSS_EN);
         @(negedge clk);
         release dut.pll_lock;
         n = 1;
         while (locked_m !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("v%0d_relock_edge", i), n, relock_exp);
         check($sformatf("v%0d_relock_retry", i), int'(retry_m), vecs[i].retries);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
